serial_link_cfg_responder: RTL
==============================

# serial_link_cfg_responder

Register-bus responder that terminates the serial link's configuration port. It holds the link control, isolation and channel-allocator configuration registers and drives them onto the link datapath. It reports synchronized AXI isolation status back to the initiator and flags isolation handshakes that never complete. It sits between the system RegBus crossbar and the serial link core, on the responder side of the bring-up sequence issued by software or bench drivers.

## Interface
- AddrWidth, 32, RegBus address width; only addr[3:2] decoded, upper bits must be 0
- SyncStages, 2, flop stages on each isolated status input (≥2)
- IsoTimeout, 1024, cycles allowed for isolation status to match request (≥2)

Ports:
- clk_1  in  1  system/config clock
- rst_1_n  in  1  reset rst_1_n, asynchronous, active-high; clock clk_1
- cfg_valid_i  in  1  request valid
- cfg_write_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  AddrWidth  byte address
- cfg_wdata_i  in  32  write data
- cfg_wstrb_i  in  4  byte strobes
- cfg_ready_o  out  1  one-cycle response strobe
- cfg_rdata_o  out  32  read data, valid with ready
- cfg_error_o  out  1  error, valid with ready
- clk_ena_o, link_rst_no  out  1 each  CTRL[0], CTRL[1]
- axi_in_isolate_o, axi_out_isolate_o  out  1 each  CTRL[8], CTRL[9]
- axi_in_isolated_i, axi_out_isolated_i  in  1 each  isolation status, asynchronous to clk_1
- tx_bypass_o, tx_auto_flush_o  out  1 each  TX_CFG[0], TX_CFG[1]
- rx_bypass_o, rx_auto_flush_o, rx_sync_en_o  out  1 each  RX_CFG[0..2]

## Operation
- Register map, word offsets; unlisted bits read 0 and ignore writes:
  - 0x0 CTRL, RW, reset 0x300. Clock off, link reset asserted, both sides isolated.
  - 0x4 ISOLATED, RO. Bit0 = synced in-isolated, bit1 = synced out-isolated, bit8 = sticky timeout.
  - 0x8 TX_CFG, RW, reset 0.
  - 0xC RX_CFG, RW, reset 0.
- Access FSM with states IDLE and RESP:
  - IDLE → RESP when cfg_valid_i=1. Address, write, data and strobes are captured; a write is applied on this edge.
  - In RESP: cfg_ready_o=1 with cfg_rdata_o and cfg_error_o; next state is IDLE unconditionally.
  - If valid is still high in IDLE after RESP, it is a new transaction.
- Writes are byte-masked by cfg_wstrb_i. wstrb=0 is a legal no-op write, error=0.
- Errors set cfg_error_o=1 in RESP and modify no state:
  - any access with addr[AddrWidth-1:4]≠0
  - write to ISOLATED
- On any error, cfg_rdata_o=0. Write responses also return rdata=0.
- Any write to CTRL, including a strobe-masked no-op, clears ISOLATED[8] and the timeout counter.
- Isolation watchdog:
  - mismatch = (synced status bits) ≠ (CTRL[8], CTRL[9]).
  - Counter increments each cycle mismatch=1 and clears when mismatch=0.
  - When the counter reaches IsoTimeout-1, ISOLATED[8] is set and the counter saturates.
  - ISOLATED[8] stays set until a CTRL write.
- All outputs are driven directly from register flops; no combinational path from inputs to outputs.

## Timing
- Reset values:
  - cfg_ready_o=0, cfg_error_o=0, cfg_rdata_o=0
  - clk_ena_o=0, link_rst_no=0
  - axi_in_isolate_o=1, axi_out_isolate_o=1
  - all TX/RX cfg outputs=0
  - sync flops=0, counter=0, sticky=0, FSM=IDLE
- Latency: valid sampled at edge N; ready is high for exactly cycle N+1. A written value appears on the control outputs from cycle N+1.
- Read data reflects register contents at edge N. A read issued in the cycle after a write response returns the new value.
- Isolated inputs reach ISOLATED bits SyncStages cycles after they change.
- Timeout fires IsoTimeout-1 cycles after mismatch first appears at the synchronizer output.
- When a CTRL write and the counter reaching threshold fall on the same edge, the CTRL write wins: sticky=0, counter=0.
- Reset asserted mid-transaction aborts it: no response is issued and all state returns to reset values immediately.

## Test plan
- Reset, then read 0x0, 0x4, 0x8, 0xC with isolated inputs held at 1 → rdata 0x300, 0x3, 0x0, 0x0; ready high one cycle each, error=0.
- Write CTRL 0x300, 0x302, 0x303 → after the last write, clk_ena_o=1, link_rst_no=1, both isolate outputs=1.
- Write TX_CFG=0x3 and RX_CFG=0x3 → tx_bypass, tx_auto_flush, rx_bypass, rx_auto_flush=1; rx_sync_en_o=0. Readback of both = 0x3.
- Write CTRL=0x03, drop both isolated inputs 5 cycles later, poll ISOLATED → reads 0x0 within SyncStages+3 cycles; bit8 never set.
- Write CTRL=0x03 with isolated inputs stuck at 1 → ISOLATED reads 0x103 after IsoTimeout cycles. A following CTRL write of 0x303 clears bit8: ISOLATED reads 0x3.
- Error cases, each → error=1 and registers unchanged:
  - write 0x4 with data 0xFFFFFFFF
  - read addr 0x10
  - write addr 0x100
- Write CTRL with wstrb=4'b0010 and data 0 → CTRL reads 0x003, so only byte 1 was modified.

Source files
------------

// File: rtl/serial_link_cfg_responder_if.sv
// rtl/serial_link_cfg_responder_if.sv - RegBus request/response bundle for the link config port.
interface serial_link_cfg_responder_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 valid;
  logic                 write;
  logic [AddrWidth-1:0] addr;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 ready;
  logic [31:0]          rdata;
  logic                 error;

  modport master (
    output valid, write, addr, wdata, wstrb,
    input  ready, rdata, error
  );

  modport slave (
    input  valid, write, addr, wdata, wstrb,
    output ready, rdata, error
  );
endinterface

// File: rtl/serial_link_cfg_responder.sv
// rtl/serial_link_cfg_responder.sv - Serial link configuration register responder.
// Holds CTRL/TX_CFG/RX_CFG, synchronizes isolation status and watches for stalled isolation handshakes.
module serial_link_cfg_responder #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned IsoTimeout = 1024
) (
  input  logic                          clk_1,
  input  logic                          rst_1_n,
  serial_link_cfg_responder_if.slave    cfg,
  output logic                          clk_ena_o,
  output logic                          link_rst_no,
  output logic                          axi_in_isolate_o,
  output logic                          axi_out_isolate_o,
  input  logic                          axi_in_isolated_i,
  input  logic                          axi_out_isolated_i,
  output logic                          tx_bypass_o,
  output logic                          tx_auto_flush_o,
  output logic                          rx_bypass_o,
  output logic                          rx_auto_flush_o,
  output logic                          rx_sync_en_o
);

  localparam int unsigned CntW = (IsoTimeout > 2) ? $clog2(IsoTimeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(IsoTimeout - 1);

  localparam logic [31:0] CtrlMask  = 32'h0000_0303;
  localparam logic [31:0] CtrlReset = 32'h0000_0300;
  localparam logic [31:0] TxMask    = 32'h0000_0003;
  localparam logic [31:0] RxMask    = 32'h0000_0007;

  typedef enum logic {IDLE, RESP} state_e;

  state_e              state_q, state_d;
  logic [31:0]         ctrl_q, ctrl_d;
  logic [31:0]         tx_q, tx_d;
  logic [31:0]         rx_q, rx_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SyncStages-1:0] in_sync_q, out_sync_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                sticky_q, sticky_d;

  logic                in_synced, out_synced;
  logic                addr_hi_err;
  logic [1:0]          sel;
  logic                ctrl_wr;
  logic                mismatch;
  logic [31:0]         rd_mux;
  logic                unused_addr_lsb;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign in_synced       = in_sync_q[SyncStages-1];
  assign out_synced      = out_sync_q[SyncStages-1];
  assign addr_hi_err     = |cfg.addr[AddrWidth-1:4];
  assign sel             = cfg.addr[3:2];
  assign unused_addr_lsb = ^cfg.addr[1:0];
  assign mismatch        = ({out_synced, in_synced} != ctrl_q[9:8]);

  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      2'd0: rd_mux = ctrl_q;
      2'd1: rd_mux = {23'h0, sticky_q, 6'h0, out_synced, in_synced};
      2'd2: rd_mux = tx_q;
      2'd3: rd_mux = rx_q;
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = 32'h0;
    ctrl_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg.valid) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (addr_hi_err || (cfg.write && sel == 2'd1)) begin
            error_d = 1'b1;
          end else if (cfg.write) begin
            case (sel)
              2'd0: begin
                ctrl_d  = apply_strb(ctrl_q, cfg.wdata, cfg.wstrb) & CtrlMask;
                ctrl_wr = 1'b1;
              end
              2'd2: tx_d = apply_strb(tx_q, cfg.wdata, cfg.wstrb) & TxMask;
              2'd3: rx_d = apply_strb(rx_q, cfg.wdata, cfg.wstrb) & RxMask;
              default: ;
            endcase
          end else begin
            rdata_d = rd_mux;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A CTRL write (even fully strobe-masked) restarts the watchdog and wins over a same-edge timeout.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (ctrl_wr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (!mismatch) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1 or posedge rst_1_n) begin
    if (rst_1_n) begin
      state_q    <= IDLE;
      ctrl_q     <= CtrlReset;
      tx_q       <= 32'h0;
      rx_q       <= 32'h0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= 32'h0;
      in_sync_q  <= '0;
      out_sync_q <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      rdata_q    <= rdata_d;
      in_sync_q  <= {in_sync_q[SyncStages-2:0], axi_in_isolated_i};
      out_sync_q <= {out_sync_q[SyncStages-2:0], axi_out_isolated_i};
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cfg.ready         = ready_q;
  assign cfg.error         = error_q;
  assign cfg.rdata         = rdata_q;
  assign clk_ena_o         = ctrl_q[0];
  assign link_rst_no       = ctrl_q[1];
  assign axi_in_isolate_o  = ctrl_q[8];
  assign axi_out_isolate_o = ctrl_q[9];
  assign tx_bypass_o       = tx_q[0];
  assign tx_auto_flush_o   = tx_q[1];
  assign rx_bypass_o       = rx_q[0];
  assign rx_auto_flush_o   = rx_q[1];
  assign rx_sync_en_o      = rx_q[2];

endmodule
